// File: rtl/cnn16_pkg.sv
// ---------------------------------------------------------------------------
// cnn16_pkg
//   Shared definitions for the CNN-16 memory subsystem: default address and
//   data widths, and the state encoding of the RAM arbiter FSM.
// ---------------------------------------------------------------------------
package cnn16_pkg;

  localparam int AW = 12;  // RAM address width
  localparam int DW = 16;  // RAM data width

  // Arbiter states:
  //   IDLE   - nobody owns the RAM, waiting for loader or CPU
  //   LOAD   - external loader owns the RAM, CPU stalled
  //   CPU_WR - single-cycle CPU write to RAM
  //   CPU_RD - CPU read address held while the RAM produces data
  //   RD_CAP - RAM read data captured into the CPU read register
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CPU_WR,
    CPU_RD,
    RD_CAP
  } arb_state_t;

endpackage

// File: rtl/cnn16_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cnn16_mem_arbiter_if
//   CPU-side memory bus of the CNN-16 core.
//   master : CPU core      (drives cpu_req/cpu_we/cpu_adr/cpu_wdata)
//   slave  : RAM arbiter   (drives cpu_rdata/mem_ready/cpu_hold)
//
//   cpu_req    request, held by the CPU until mem_ready
//   cpu_we     1 = write, 0 = read
//   cpu_adr    word address
//   cpu_wdata  write data
//   cpu_rdata  registered read data, valid while mem_ready = 1
//   mem_ready  one-cycle completion pulse
//   cpu_hold   loader owns the RAM; the CPU must stall
// ---------------------------------------------------------------------------
interface cnn16_mem_arbiter_if #(
  parameter int AW = cnn16_pkg::AW,
  parameter int DW = cnn16_pkg::DW
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          mem_ready;
  logic          cpu_hold;

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_rdata, mem_ready, cpu_hold
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_rdata, mem_ready, cpu_hold
  );

endinterface

// File: rtl/cnn16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cnn16_mem_arbiter
//   Shares the single-port CNN-16 program/data RAM between the external
//   program loader and the CPU core, and generates the CPU's mem_ready
//   handshake. The loader has priority but never preempts a CPU access that
//   is already in flight. CPU accesses are registered and sequenced through
//   a small FSM that waits out the RAM read latency.
//
// Parameters
//   AW        address width
//   DW        data width
//   RD_LAT    RAM read latency in cycles (legal 1..3)
//   PROG_TOP  highest write-protected address (protection build only)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   cpu        CPU memory bus (slave side of cnn16_mem_arbiter_if)
//   ld_sel     loader requests RAM ownership
//   ld_we      loader write strobe, one word per cycle
//   ld_adr     loader address
//   ld_data    loader write data
//   owner      0 = CPU, 1 = loader
//   ram_we     RAM write enable
//   ram_adr    RAM address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data
//   wp_err     pulses with mem_ready when a CPU write was suppressed
//
// Build option
//   CNN16_ARB_WPROT_EN  when defined, CPU writes to addresses <= PROG_TOP
//                       are dropped and flagged on wp_err; loader writes are
//                       never protected. When undefined wp_err is always 0.
// ---------------------------------------------------------------------------
module cnn16_mem_arbiter
  import cnn16_pkg::arb_state_t;
  import cnn16_pkg::IDLE;
  import cnn16_pkg::LOAD;
  import cnn16_pkg::CPU_WR;
  import cnn16_pkg::CPU_RD;
  import cnn16_pkg::RD_CAP;
#(
  parameter int            AW       = cnn16_pkg::AW,
  parameter int            DW       = cnn16_pkg::DW,
  parameter int            RD_LAT   = 1,
  parameter logic [AW-1:0] PROG_TOP = 12'h0FF
) (
  input  logic                clk,
  input  logic                rst,

  cnn16_mem_arbiter_if.slave  cpu,

  input  logic                ld_sel,
  input  logic                ld_we,
  input  logic [AW-1:0]       ld_adr,
  input  logic [DW-1:0]       ld_data,

  output logic                owner,

  output logic                ram_we,
  output logic [AW-1:0]       ram_adr,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata,

  output logic                wp_err
);

`ifdef CNN16_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  // The counter is loaded with RD_LAT-1 so CPU_RD lasts exactly RD_LAT cycles.
  localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

  arb_state_t    state, state_d;
  logic [AW-1:0] lat_adr;
  logic [DW-1:0] lat_wdata;
  logic [1:0]    rd_cnt;
  logic [DW-1:0] cpu_rdata_q;
  logic          mem_ready_q;
  logic          wp_err_q;
  logic          accept;
  logic          wp_hit;

  // Constant-false in the unprotected build, so no write is ever suppressed.
  assign wp_hit = WPROT_EN && (lat_adr <= PROG_TOP);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and RAM-side outputs.
  // NOTE: every output gets a default at the top of the block; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = lat_adr;
    ram_wdata = lat_wdata;

    unique case (state)
      IDLE: begin
        // Loader wins a same-cycle tie. A request still visible during the
        // mem_ready cycle belongs to the access that just finished.
        if (ld_sel) begin
          state_d = LOAD;
        end else if (cpu.cpu_req && !mem_ready_q) begin
          accept  = 1'b1;
          state_d = cpu.cpu_we ? CPU_WR : CPU_RD;
        end
      end
      LOAD: begin
        // Loader drives the RAM directly so its writes land this cycle.
        ram_we    = ld_we;
        ram_adr   = ld_adr;
        ram_wdata = ld_data;
        if (!ld_sel) state_d = IDLE;
      end
      CPU_WR: begin
        ram_we  = !wp_hit;
        state_d = IDLE;
      end
      CPU_RD: begin
        if (rd_cnt == 2'd0) state_d = RD_CAP;
      end
      RD_CAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset arriving in the write cycle aborts the write, not just the FSM.
    if (rst) ram_we = 1'b0;
  end

  // CPU request latch, read-latency counter and CPU-side response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_adr     <= '0;
      lat_wdata   <= '0;
      rd_cnt      <= 2'd0;
      cpu_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      wp_err_q    <= 1'b0;
    end else begin
      mem_ready_q <= (state == CPU_WR) || (state == RD_CAP);
      wp_err_q    <= (state == CPU_WR) && wp_hit;

      if (accept) begin
        lat_adr   <= cpu.cpu_adr;
        lat_wdata <= cpu.cpu_wdata;
        rd_cnt    <= RD_CNT_INIT;
      end else if ((state == CPU_RD) && (rd_cnt != 2'd0)) begin
        rd_cnt <= rd_cnt - 2'd1;
      end

      if (state == RD_CAP) cpu_rdata_q <= ram_rdata;
    end
  end

  assign owner         = (state == LOAD);
  assign cpu.cpu_hold  = (state == LOAD);
  assign cpu.mem_ready = mem_ready_q;
  assign cpu.cpu_rdata = cpu_rdata_q;
  assign wp_err        = wp_err_q;

endmodule

// File: tb/tb_cnn16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cnn16_mem_arbiter
//   Directed bench for cnn16_mem_arbiter. Two instances: dut1 with the
//   default one-cycle RAM and dut3 with a three-cycle RAM. Each has a small
//   behavioural RAM model with the matching read latency. Inputs change 1 ns
//   after the rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cnn16_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mem_clr;
  logic          ld_sel;
  logic          ld_we;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_data;

  cnn16_mem_arbiter_if #(.AW(AW), .DW(DW)) cif1 ();
  cnn16_mem_arbiter_if #(.AW(AW), .DW(DW)) cif3 ();

  logic          owner1, ram_we1, wp_err1;
  logic [AW-1:0] ram_adr1;
  logic [DW-1:0] ram_wdata1, ram_rdata1;

  logic          owner3, ram_we3, wp_err3;
  logic [AW-1:0] ram_adr3;
  logic [DW-1:0] ram_wdata3, ram_rdata3;

  cnn16_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cif1),
    .ld_sel    (ld_sel),
    .ld_we     (ld_we),
    .ld_adr    (ld_adr),
    .ld_data   (ld_data),
    .owner     (owner1),
    .ram_we    (ram_we1),
    .ram_adr   (ram_adr1),
    .ram_wdata (ram_wdata1),
    .ram_rdata (ram_rdata1),
    .wp_err    (wp_err1)
  );

  cnn16_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cif3),
    .ld_sel    (1'b0),
    .ld_we     (1'b0),
    .ld_adr    ('0),
    .ld_data   ('0),
    .owner     (owner3),
    .ram_we    (ram_we3),
    .ram_adr   (ram_adr3),
    .ram_wdata (ram_wdata3),
    .ram_rdata (ram_rdata3),
    .wp_err    (wp_err3)
  );

  // RAM models
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] rd3_p0, rd3_p1;
  int            wr_cnt1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem1[i] <= '0;
      wr_cnt1 <= 0;
    end else if (ram_we1) begin
      mem1[ram_adr1] <= ram_wdata1;
      wr_cnt1        <= wr_cnt1 + 1;
    end
    ram_rdata1 <= mem1[ram_adr1];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem3[i] <= '0;
    end else if (ram_we3) begin
      mem3[ram_adr3] <= ram_wdata3;
    end
    rd3_p0     <= mem3[ram_adr3];
    rd3_p1     <= rd3_p0;
    ram_rdata3 <= rd3_p1;
  end

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU access starting in the current cycle (N) and wait for
  // mem_ready. lat = cycles from N to mem_ready, we_k = first cycle after N
  // with ram_we high (-1 if none). Request drops in the mem_ready cycle.
  task automatic cpu_access(input bit use3, input bit we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] wdata, output int lat,
                            output logic [DW-1:0] rdata, output int we_k,
                            output logic wp_seen);
    lat     = -1;
    we_k    = -1;
    wp_seen = 1'b0;
    rdata   = '0;
    if (use3) begin
      cif3.cpu_req = 1'b1; cif3.cpu_we = we; cif3.cpu_adr = adr; cif3.cpu_wdata = wdata;
    end else begin
      cif1.cpu_req = 1'b1; cif1.cpu_we = we; cif1.cpu_adr = adr; cif1.cpu_wdata = wdata;
    end
    #1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      #1;
      if ((use3 ? ram_we3 : ram_we1) && (we_k < 0)) we_k = k;
      if (use3 ? cif3.mem_ready : cif1.mem_ready) begin
        lat     = k;
        rdata   = use3 ? cif3.cpu_rdata : cif1.cpu_rdata;
        wp_seen = use3 ? wp_err3 : wp_err1;
        break;
      end
    end
    cif1.cpu_req = 1'b0;
    cif3.cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, we_k, w0;
    logic [DW-1:0] rd;
    logic          wp;

    rst = 1'b1; mem_clr = 1'b1;
    ld_sel = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_data = '0;
    cif1.cpu_req = 1'b0; cif1.cpu_we = 1'b0; cif1.cpu_adr = '0; cif1.cpu_wdata = '0;
    cif3.cpu_req = 1'b0; cif3.cpu_we = 1'b0; cif3.cpu_adr = '0; cif3.cpu_wdata = '0;
    cyc();
    mem_clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst owner",     32'(owner1),         32'h0);
    check("rst cpu_hold",  32'(cif1.cpu_hold),  32'h0);
    check("rst mem_ready", 32'(cif1.mem_ready), 32'h0);
    check("rst cpu_rdata", 32'(cif1.cpu_rdata), 32'h0);
    check("rst wp_err",    32'(wp_err1),        32'h0);
    check("rst ram_we",    32'(ram_we1),        32'h0);
    check("rst ram_adr",   32'(ram_adr1),       32'h0);

    // Loader load
    cyc();
    ld_sel = 1'b1; ld_we = 1'b1; ld_adr = 12'h010; ld_data = 16'hA5A5;
    #1;
    check("ld entry owner",  32'(owner1),  32'h0);
    check("ld entry ram_we", 32'(ram_we1), 32'h0);
    cyc();
    #1;
    check("ld owner",     32'(owner1),        32'h1);
    check("ld cpu_hold",  32'(cif1.cpu_hold), 32'h1);
    check("ld ram_we",    32'(ram_we1),       32'h1);
    check("ld ram_adr",   32'(ram_adr1),      32'h010);
    check("ld ram_wdata", 32'(ram_wdata1),    32'hA5A5);
    cyc();
    ld_adr = 12'h011; ld_data = 16'h5A5A;
    cyc();
    ld_sel = 1'b0; ld_we = 1'b0;
    #1;
    check("ld exit owner still", 32'(owner1), 32'h1);
    cyc();
    #1;
    check("ld idle owner", 32'(owner1),     32'h0);
    check("ld mem 010",    32'(mem1[12'h010]), 32'hA5A5);
    check("ld mem 011",    32'(mem1[12'h011]), 32'h5A5A);
    cpu_access(1'b0, 1'b0, 12'h010, '0, lat, rd, we_k, wp);
    check("rd 010 lat",  32'(lat), 32'd3);
    check("rd 010 data", 32'(rd),  32'hA5A5);

    // CPU write then read
    cyc();
    cpu_access(1'b0, 1'b1, 12'h200, 16'h1234, lat, rd, we_k, wp);
    check("wr 200 lat",    32'(lat),  32'd2);
    check("wr 200 we_k",   32'(we_k), 32'd1);
    check("wr 200 mem",    32'(mem1[12'h200]), 32'h1234);
    cyc();
    cpu_access(1'b0, 1'b0, 12'h200, '0, lat, rd, we_k, wp);
    check("rd 200 lat",  32'(lat),  32'd3);
    check("rd 200 data", 32'(rd),   32'h1234);
    check("rd 200 no we", 32'(we_k), 32'hFFFF_FFFF);

    // Collision: loader and CPU request in the same cycle
    cyc();
    ld_sel = 1'b1; ld_we = 1'b0;
    cif1.cpu_req = 1'b1; cif1.cpu_we = 1'b1; cif1.cpu_adr = 12'h300; cif1.cpu_wdata = 16'hBEEF;
    #1;
    check("col c0 ram_we", 32'(ram_we1), 32'h0);
    cyc();
    #1;
    check("col c1 owner", 32'(owner1),        32'h1);
    check("col c1 hold",  32'(cif1.cpu_hold), 32'h1);
    cyc();
    ld_we = 1'b1; ld_adr = 12'h020; ld_data = 16'h1111;
    #1;
    check("col c2 ready",  32'(cif1.mem_ready), 32'h0);
    check("col c2 ram_we", 32'(ram_we1),        32'h1);
    cyc();
    ld_sel = 1'b0; ld_we = 1'b0;
    cyc();
    #1;
    check("col c4 owner", 32'(owner1), 32'h0);
    cyc();
    #1;
    check("col c5 ram_we",    32'(ram_we1),    32'h1);
    check("col c5 ram_adr",   32'(ram_adr1),   32'h300);
    check("col c5 ram_wdata", 32'(ram_wdata1), 32'hBEEF);
    cyc();
    #1;
    check("col c6 ready", 32'(cif1.mem_ready), 32'h1);
    cif1.cpu_req = 1'b0;
    check("col mem 300", 32'(mem1[12'h300]), 32'hBEEF);
    check("col mem 020", 32'(mem1[12'h020]), 32'h1111);

    // Loader request while a CPU read is in flight
    cyc();
    cif1.cpu_req = 1'b1; cif1.cpu_we = 1'b0; cif1.cpu_adr = 12'h200;
    cyc();
    ld_sel = 1'b1; ld_we = 1'b1; ld_adr = 12'h200; ld_data = 16'hDEAD;
    #1;
    check("lrd n1 ram_we", 32'(ram_we1), 32'h0);
    check("lrd n1 owner",  32'(owner1),  32'h0);
    cyc();
    #1;
    check("lrd n2 ram_we", 32'(ram_we1), 32'h0);
    cyc();
    #1;
    check("lrd n3 ready",  32'(cif1.mem_ready), 32'h1);
    check("lrd n3 data",   32'(cif1.cpu_rdata), 32'h1234);
    check("lrd n3 owner",  32'(owner1),         32'h0);
    check("lrd n3 ram_we", 32'(ram_we1),        32'h0);
    cif1.cpu_req = 1'b0;
    cyc();
    ld_we = 1'b0;
    #1;
    check("lrd n4 owner", 32'(owner1), 32'h1);
    check("lrd mem 200",  32'(mem1[12'h200]), 32'h1234);
    cyc();
    ld_sel = 1'b0;
    cyc();

    // Reset in the middle of a read
    cyc();
    cif1.cpu_req = 1'b1; cif1.cpu_we = 1'b0; cif1.cpu_adr = 12'h010;
    cyc();
    rst = 1'b1; cif1.cpu_req = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    check("rrd ready",   32'(cif1.mem_ready), 32'h0);
    check("rrd rdata",   32'(cif1.cpu_rdata), 32'h0);
    check("rrd ram_adr", 32'(ram_adr1),       32'h0);
    check("rrd owner",   32'(owner1),         32'h0);
    cyc();
    #1;
    check("rrd late ready", 32'(cif1.mem_ready), 32'h0);

    // Reset in the write cycle: the write must not reach the RAM
    cyc();
    w0 = wr_cnt1;
    cif1.cpu_req = 1'b1; cif1.cpu_we = 1'b1; cif1.cpu_adr = 12'h400; cif1.cpu_wdata = 16'h7777;
    cyc();
    rst = 1'b1; cif1.cpu_req = 1'b0;
    #1;
    check("rwr ram_we", 32'(ram_we1), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("rwr ready",   32'(cif1.mem_ready), 32'h0);
    check("rwr wr_cnt",  32'(wr_cnt1),        32'(w0));
    check("rwr mem 400", 32'(mem1[12'h400]),  32'h0);
    cyc();
    #1;
    check("rwr late ready", 32'(cif1.mem_ready), 32'h0);
    cpu_access(1'b0, 1'b0, 12'h010, '0, lat, rd, we_k, wp);
    check("post rst lat",  32'(lat), 32'd3);
    check("post rst data", 32'(rd),  32'hA5A5);

    // Write protection boundary
    cyc();
    w0 = wr_cnt1;
    cpu_access(1'b0, 1'b1, 12'h0FF, 16'hFFFF, lat, rd, we_k, wp);
    check("wp 0ff lat", 32'(lat), 32'd2);
`ifdef CNN16_ARB_WPROT_EN
    check("wp 0ff wp_err", 32'(wp),   32'h1);
    check("wp 0ff we_k",   32'(we_k), 32'hFFFF_FFFF);
    check("wp 0ff wr_cnt", 32'(wr_cnt1), 32'(w0));
    check("wp 0ff mem",    32'(mem1[12'h0FF]), 32'h0);
`else
    check("wp 0ff wp_err", 32'(wp),   32'h0);
    check("wp 0ff we_k",   32'(we_k), 32'd1);
    check("wp 0ff mem",    32'(mem1[12'h0FF]), 32'hFFFF);
`endif
    cyc();
    #1;
    check("wp pulse end", 32'(wp_err1), 32'h0);
    cpu_access(1'b0, 1'b1, 12'h100, 16'hFFFF, lat, rd, we_k, wp);
    check("wp 100 lat",    32'(lat),  32'd2);
    check("wp 100 wp_err", 32'(wp),   32'h0);
    check("wp 100 we_k",   32'(we_k), 32'd1);
    check("wp 100 mem",    32'(mem1[12'h100]), 32'hFFFF);

    // Three-cycle RAM
    cyc();
    cpu_access(1'b1, 1'b1, 12'h200, 16'h1234, lat, rd, we_k, wp);
    check("l3 wr lat",  32'(lat),  32'd2);
    check("l3 wr we_k", 32'(we_k), 32'd1);
    cyc();
    cpu_access(1'b1, 1'b0, 12'h200, '0, lat, rd, we_k, wp);
    check("l3 rd lat",  32'(lat), 32'd5);
    check("l3 rd data", 32'(rd),  32'h1234);
    check("l3 owner",   32'(owner3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
